multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
Multi-cycle sequencer for the RV64 integer core. Decodes opcode from the instruction register and steps the shared datapath (register file, immediate extractor, ALU, unified memory port) through FETCH/DECODE/EXECUTE/MEM/WRITEBACK. It emits per-state control strobes and handles memory wait-states, bus timeouts and illegal opcodes. It also keeps cycle and retired-instruction counters.

Parameters:
TIMEOUT, 16, max cycles a memory request may wait for mem_ready before a bus error
CNT_W, 32, width of cycle_count and instret_count

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
instruction  in  32  current IR contents (valid from DECODE onward)
branch_taken  in  1  ALU compare result, sampled in EXECUTE for branches
mem_ready  in  1  memory completes the request this cycle
mem_req  out  1  memory request strobe
mem_we  out  1  write enable (store)
addr_sel  out  1  0 = PC addresses memory, 1 = ALU result addresses memory
ir_write  out  1  latch memory read data into IR
reg_write  out  1  register-file write enable
mem_to_reg  out  1  writeback source: 0 = ALU, 1 = memory data
alu_src  out  1  ALU operand B: 0 = rs2, 1 = immediate
alu_op  out  2  00 = add, 01 = subtract/compare, 10 = funct3/funct7 decoded
pc_write  out  1  update PC this cycle
pc_src  out  1  0 = PC+4, 1 = branch target
trap  out  1  sticky halt indicator
trap_cause  out  2  00 = none, 01 = illegal opcode, 10 = bus timeout
state  out  3  current state encoding for debug
cycle_count  out  CNT_W  cycles since reset, excluding TRAP
instret_count  out  CNT_W  retired instructions

Behaviour:
- Reset (reset=0, async): state=FETCH. All strobes=0. alu_op=00, trap=0, trap_cause=00. Both counters=0, wait counter=0.
- State encodings: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, TRAP=7.
- FETCH: mem_req=1, addr_sel=0. On mem_ready, ir_write=1 in the same cycle, then go to DECODE. Otherwise stay in FETCH.
- DECODE: one cycle with no strobes. Decode instruction[6:0]:
  - 0110011 (R-type) -> EXECUTE
  - 0010011 (I-type ALU) -> EXECUTE
  - 0000011 (load) -> EXECUTE
  - 0100011 (store) -> EXECUTE
  - 1100011 (branch) -> EXECUTE
  - any other opcode -> TRAP, trap_cause=01
- EXECUTE controls by type:
  - R-type: alu_src=0, alu_op=10, then WRITEBACK.
  - I-type ALU: alu_src=1, alu_op=10, then WRITEBACK.
  - Load/store: alu_src=1, alu_op=00, then MEM.
  - Branch: alu_src=0, alu_op=01, pc_write=1, pc_src=branch_taken; the instruction retires; next state FETCH.
- MEM: mem_req=1, addr_sel=1, mem_we=1 for stores. Hold alu_op=00 and alu_src=1.
  - On mem_ready, a load goes to WRITEBACK.
  - On mem_ready, a store asserts pc_write=1, pc_src=0, retires, and goes to FETCH.
- WRITEBACK: reg_write=1; mem_to_reg=1 for loads, 0 otherwise; pc_write=1, pc_src=0; retires; next state FETCH.
- Retire: instret_count increments on the cycle pc_write=1.
- Latency with zero wait-states:
  - R/I-type: 4 cycles
  - load: 5 cycles
  - store: 4 cycles
  - branch: 3 cycles
  - Each cycle that mem_ready stays low adds one cycle.
- Timeout:
  - The wait counter clears on entry to FETCH/MEM and on mem_ready.
  - It increments on each cycle with mem_req=1 and mem_ready=0.
  - When the counter reaches TIMEOUT, go to TRAP with trap_cause=10. No ir_write or reg_write occurs.
- mem_ready outside FETCH/MEM is ignored.
- TRAP:
  - All strobes=0, trap=1, and trap_cause is held.
  - The counters freeze.
  - Only reset exits TRAP.
- cycle_count increments every non-TRAP cycle and wraps modulo 2^CNT_W. instret_count also wraps modulo 2^CNT_W.
- Reset asserted mid-instruction aborts immediately. No partial write completes after reset deasserts, and the sequence restarts in FETCH.
- All control outputs are combinational from state plus the decoded opcode. state, the counters and trap are registered.

Test Plan:
- R-type add (0x00B50533), mem_ready=1 on first FETCH cycle -> states 0,1,2,4; reg_write=1 only in cycle 4; instret_count 0->1 after 4 cycles; cycle_count=4.
- Load ld (opcode 0000011), mem_ready delayed 3 cycles in MEM -> MEM held 4 cycles with addr_sel=1, mem_we=0; WRITEBACK has mem_to_reg=1; total 8 cycles.
- Store, then taken branch (branch_taken=1) -> store: mem_we=1 only in MEM, no reg_write; branch: pc_write=1, pc_src=1 in EXECUTE, 3 cycles, instret_count=2.
- Illegal opcode 0x0000007F -> TRAP after DECODE, trap=1, trap_cause=01; counters frozen for 20 further cycles; reset low -> state=0, trap=0.
- mem_ready held low in FETCH with TIMEOUT=16 -> TRAP after 16 wait cycles, trap_cause=10, ir_write never asserted.
- Reset pulsed low during MEM of a store -> mem_we drops asynchronously; after release, FETCH with counters 0, no pc_write observed.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for the RV64 integer core.
// Steps the shared datapath through FETCH/DECODE/EXECUTE/MEM/WRITEBACK,
// raises per-state control strobes, times out stalled memory requests,
// traps on illegal opcodes and keeps cycle / retired-instruction counters.
module multicycle_control #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,          // asynchronous, active-low
  input  logic [31:0]      instruction,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_write,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             pc_write,
  output logic             pc_src,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instret_count
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    CLS_RTYPE,
    CLS_ITYPE,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_ILLEGAL
  } op_class_t;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  // Wide enough to hold TIMEOUT itself; the request gives up on the cycle
  // the count would reach TIMEOUT.
  localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t            r_state;
  state_t            w_next_state;
  op_class_t         r_class;
  op_class_t         w_dec_class;
  logic [WAIT_W-1:0] r_wait;
  logic              r_trap;
  logic [1:0]        r_trap_cause;
  logic [CNT_W-1:0]  r_cycle_count;
  logic [CNT_W-1:0]  r_instret_count;
  logic              w_waiting;
  logic              w_wait_expire;
  logic              w_unused;

  // Only the opcode field steers the sequencer; funct fields go to the ALU.
  assign w_unused = ^instruction[31:7];

  // Classify the opcode currently in the IR.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    w_dec_class = CLS_ILLEGAL;
    case (instruction[6:0])
      OPC_RTYPE:  w_dec_class = CLS_RTYPE;
      OPC_ITYPE:  w_dec_class = CLS_ITYPE;
      OPC_LOAD:   w_dec_class = CLS_LOAD;
      OPC_STORE:  w_dec_class = CLS_STORE;
      OPC_BRANCH: w_dec_class = CLS_BRANCH;
      default:    w_dec_class = CLS_ILLEGAL;
    endcase
  end

  // Control strobes from the current state and the latched instruction class;
  // held low while reset is asserted so an in-flight access is dropped at once.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_sel   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    alu_op     = ALU_ADD;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    if (reset) begin
      case (r_state)
        S_FETCH: begin
          mem_req  = 1'b1;
          ir_write = mem_ready;
        end
        S_EXECUTE: begin
          case (r_class)
            CLS_RTYPE: alu_op = ALU_FUNCT;
            CLS_ITYPE: begin
              alu_src = 1'b1;
              alu_op  = ALU_FUNCT;
            end
            CLS_LOAD, CLS_STORE: alu_src = 1'b1;
            CLS_BRANCH: begin
              alu_op   = ALU_SUB;
              pc_write = 1'b1;
              pc_src   = branch_taken;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          alu_src  = 1'b1;
          mem_we   = (r_class == CLS_STORE);
          pc_write = (r_class == CLS_STORE) && mem_ready;
        end
        S_WRITEBACK: begin
          reg_write  = 1'b1;
          mem_to_reg = (r_class == CLS_LOAD);
          pc_write   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign w_waiting     = mem_req && !mem_ready;
  assign w_wait_expire = w_waiting && (r_wait == WAIT_LAST);

  // Next-state selection.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH: begin
        if (mem_ready)          w_next_state = S_DECODE;
        else if (w_wait_expire) w_next_state = S_TRAP;
        else                    w_next_state = S_FETCH;
      end
      S_DECODE:
        w_next_state = (w_dec_class == CLS_ILLEGAL) ? S_TRAP : S_EXECUTE;
      S_EXECUTE: begin
        case (r_class)
          CLS_RTYPE, CLS_ITYPE: w_next_state = S_WRITEBACK;
          CLS_LOAD, CLS_STORE:  w_next_state = S_MEM;
          default:              w_next_state = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (mem_ready)
          w_next_state = (r_class == CLS_LOAD) ? S_WRITEBACK : S_FETCH;
        else if (w_wait_expire)
          w_next_state = S_TRAP;
        else
          w_next_state = S_MEM;
      end
      S_WRITEBACK: w_next_state = S_FETCH;
      S_TRAP:      w_next_state = S_TRAP;
      default:     w_next_state = S_FETCH;
    endcase
  end

  // Sequencer state, instruction class, wait counter, trap flag and counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= S_FETCH;
      r_class         <= CLS_ILLEGAL;
      r_wait          <= '0;
      r_trap          <= 1'b0;
      r_trap_cause    <= 2'b00;
      r_cycle_count   <= '0;
      r_instret_count <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      r_state <= w_next_state;

      if (r_state == S_DECODE)
        r_class <= w_dec_class;

      // Counts consecutive stalled cycles; any non-waiting cycle clears it,
      // which covers both entry to FETCH/MEM and a completed request.
      if (w_waiting) r_wait <= r_wait + 1'b1;
      else           r_wait <= '0;

      if (r_state != S_TRAP && w_next_state == S_TRAP) begin
        r_trap       <= 1'b1;
        r_trap_cause <= (r_state == S_DECODE) ? CAUSE_ILLEGAL : CAUSE_TIMEOUT;
      end

      if (r_state != S_TRAP)
        r_cycle_count <= r_cycle_count + 1'b1;

      if (pc_write)
        r_instret_count <= r_instret_count + 1'b1;
    end
  end

  assign state         = r_state;
  assign trap          = r_trap;
  assign trap_cause    = r_trap_cause;
  assign cycle_count   = r_cycle_count;
  assign instret_count = r_instret_count;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a per-cycle vector table covering
// every instruction class, plus hand sequences for illegal-opcode trap,
// fetch timeout and reset mid-store.
module tb_multicycle_control;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 32;

  localparam logic [31:0] R_ADD  = 32'h00B50533;  // add  x10,x10,x11
  localparam logic [31:0] I_ADDI = 32'h00500093;  // addi x1,x0,5
  localparam logic [31:0] L_LD   = 32'h00053283;  // ld   x5,0(x10)
  localparam logic [31:0] S_SD   = 32'h00553423;  // sd   x5,8(x10)
  localparam logic [31:0] B_BEQ  = 32'h00208463;  // beq  x1,x2,+8
  localparam logic [31:0] ILL    = 32'h0000007F;

  localparam logic [2:0] ST_F = 3'd0, ST_D = 3'd1, ST_E = 3'd2,
                         ST_M = 3'd3, ST_W = 3'd4, ST_T = 3'd7;

  // Expected control bundle, bit order:
  // mem_req mem_we addr_sel ir_write reg_write mem_to_reg alu_src
  // alu_op[1:0] pc_write pc_src trap trap_cause[1:0]
  localparam logic [13:0] K_NONE     = 14'b0_0_0_0_0_0_0_00_0_0_0_00;
  localparam logic [13:0] K_FETCH    = 14'b1_0_0_0_0_0_0_00_0_0_0_00;
  localparam logic [13:0] K_FETCHR   = 14'b1_0_0_1_0_0_0_00_0_0_0_00;
  localparam logic [13:0] K_EX_R     = 14'b0_0_0_0_0_0_0_10_0_0_0_00;
  localparam logic [13:0] K_EX_I     = 14'b0_0_0_0_0_0_1_10_0_0_0_00;
  localparam logic [13:0] K_EX_LS    = 14'b0_0_0_0_0_0_1_00_0_0_0_00;
  localparam logic [13:0] K_EX_BT    = 14'b0_0_0_0_0_0_0_01_1_1_0_00;
  localparam logic [13:0] K_EX_BN    = 14'b0_0_0_0_0_0_0_01_1_0_0_00;
  localparam logic [13:0] K_MEM_LD   = 14'b1_0_1_0_0_0_1_00_0_0_0_00;
  localparam logic [13:0] K_MEM_ST   = 14'b1_1_1_0_0_0_1_00_0_0_0_00;
  localparam logic [13:0] K_MEM_STR  = 14'b1_1_1_0_0_0_1_00_1_0_0_00;
  localparam logic [13:0] K_WB_ALU   = 14'b0_0_0_0_1_0_0_00_1_0_0_00;
  localparam logic [13:0] K_WB_LD    = 14'b0_0_0_0_1_1_0_00_1_0_0_00;
  localparam logic [13:0] K_TRAP_ILL = 14'b0_0_0_0_0_0_0_00_0_0_1_01;
  localparam logic [13:0] K_TRAP_TO  = 14'b0_0_0_0_0_0_0_00_0_0_1_10;

  typedef struct {
    logic             rdy;
    logic             tkn;
    logic [31:0]      ins;
    logic [2:0]       st;
    logic [13:0]      ctl;
    logic [CNT_W-1:0] ret;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [31:0]      instruction = '0;
  logic             branch_taken = 1'b0;
  logic             mem_ready = 1'b0;
  logic             mem_req, mem_we, addr_sel, ir_write, reg_write, mem_to_reg;
  logic             alu_src, pc_write, pc_src, trap;
  logic [1:0]       alu_op, trap_cause;
  logic [2:0]       state;
  logic [CNT_W-1:0] cycle_count, instret_count;

  int   n_pass  = 0;
  int   n_total = 0;
  vec_t tbl[$];

  multicycle_control #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .instruction(instruction),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
    .ir_write(ir_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .alu_src(alu_src), .alu_op(alu_op), .pc_write(pc_write), .pc_src(pc_src),
    .trap(trap), .trap_cause(trap_cause), .state(state),
    .cycle_count(cycle_count), .instret_count(instret_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [13:0] act_ctl();
    return {mem_req, mem_we, addr_sel, ir_write, reg_write, mem_to_reg, alu_src,
            alu_op, pc_write, pc_src, trap, trap_cause};
  endfunction

  task automatic add(input int rdy, input int tkn, input logic [31:0] ins,
                     input logic [2:0] st, input logic [13:0] ctl, input int ret);
    tbl.push_back(vec_t'{1'(rdy), 1'(tkn), ins, st, ctl, CNT_W'(ret)});
  endtask

  // Called at a falling edge: drive one cycle's inputs, check, move to next falling edge.
  task automatic apply(input vec_t v, input string tag, input int exp_cyc);
    mem_ready    = v.rdy;
    branch_taken = v.tkn;
    instruction  = v.ins;
    #1;
    check({tag, ".state"},   64'(state),         64'(v.st));
    check({tag, ".ctl"},     64'(act_ctl()),     64'(v.ctl));
    check({tag, ".cycle"},   64'(cycle_count),   64'(exp_cyc));
    check({tag, ".instret"}, 64'(instret_count), 64'(v.ret));
    @(negedge clk);
  endtask

  // Assert reset off-edge, check the asynchronous result, release at a falling edge.
  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    check({tag, ".state"},   64'(state),         64'(ST_F));
    check({tag, ".ctl"},     64'(act_ctl()),     64'(K_NONE));
    check({tag, ".cycle"},   64'(cycle_count),   64'd0);
    check({tag, ".instret"}, 64'(instret_count), 64'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    // add: zero wait-states, 4 cycles
    add(1,0,R_ADD,ST_F,K_FETCHR,0); add(0,0,R_ADD,ST_D,K_NONE,0);
    add(0,0,R_ADD,ST_E,K_EX_R,0);   add(0,0,R_ADD,ST_W,K_WB_ALU,0);
    // ld: three wait-states in MEM, 8 cycles
    add(1,0,L_LD,ST_F,K_FETCHR,1);  add(0,0,L_LD,ST_D,K_NONE,1);
    add(0,0,L_LD,ST_E,K_EX_LS,1);   add(0,0,L_LD,ST_M,K_MEM_LD,1);
    add(0,0,L_LD,ST_M,K_MEM_LD,1);  add(0,0,L_LD,ST_M,K_MEM_LD,1);
    add(1,0,L_LD,ST_M,K_MEM_LD,1);  add(0,0,L_LD,ST_W,K_WB_LD,1);
    // addi: two wait-states in FETCH, 6 cycles
    add(0,0,I_ADDI,ST_F,K_FETCH,2); add(0,0,I_ADDI,ST_F,K_FETCH,2);
    add(1,0,I_ADDI,ST_F,K_FETCHR,2); add(0,0,I_ADDI,ST_D,K_NONE,2);
    add(0,0,I_ADDI,ST_E,K_EX_I,2);  add(0,0,I_ADDI,ST_W,K_WB_ALU,2);
    // sd: 4 cycles, retires from MEM
    add(1,0,S_SD,ST_F,K_FETCHR,3);  add(0,0,S_SD,ST_D,K_NONE,3);
    add(0,0,S_SD,ST_E,K_EX_LS,3);   add(1,0,S_SD,ST_M,K_MEM_STR,3);
    // beq taken, stray mem_ready in DECODE/EXECUTE must be ignored
    add(1,1,B_BEQ,ST_F,K_FETCHR,4); add(1,1,B_BEQ,ST_D,K_NONE,4);
    add(1,1,B_BEQ,ST_E,K_EX_BT,4);
    // beq not taken
    add(1,0,B_BEQ,ST_F,K_FETCHR,5); add(0,0,B_BEQ,ST_D,K_NONE,5);
    add(0,0,B_BEQ,ST_E,K_EX_BN,5);

    #1;
    do_reset("rst0");
    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i], $sformatf("v%0d", i), i);
    mem_ready = 1'b0;
    #1;
    check("seq.state",   64'(state),         64'(ST_F));
    check("seq.cycle",   64'(cycle_count),   64'd28);
    check("seq.instret", 64'(instret_count), 64'd6);

    // Illegal opcode: trap after DECODE, counters frozen while trapped.
    #2;
    do_reset("rst1");
    apply(vec_t'{1'b1, 1'b0, ILL, ST_F, K_FETCHR, '0}, "ill.f", 0);
    apply(vec_t'{1'b0, 1'b0, ILL, ST_D, K_NONE, '0}, "ill.d", 1);
    apply(vec_t'{1'b1, 1'b0, ILL, ST_T, K_TRAP_ILL, '0}, "ill.t", 2);
    for (int i = 0; i < 20; i++)
      apply(vec_t'{1'(i % 2), 1'b0, R_ADD, ST_T, K_TRAP_ILL, '0}, $sformatf("ill.hold%0d", i), 2);

    // Fetch timeout: 16 stalled cycles, then TRAP with no ir_write.
    #2;
    do_reset("rst2");
    for (int i = 0; i < TIMEOUT; i++)
      apply(vec_t'{1'b0, 1'b0, R_ADD, ST_F, K_FETCH, '0}, $sformatf("to.w%0d", i), i);
    apply(vec_t'{1'b0, 1'b0, R_ADD, ST_T, K_TRAP_TO, '0}, "to.trap", TIMEOUT);
    apply(vec_t'{1'b1, 1'b0, R_ADD, ST_T, K_TRAP_TO, '0}, "to.late", TIMEOUT);

    // Reset during MEM of a store: mem_we drops at once, no retirement after.
    #2;
    do_reset("rst3");
    apply(vec_t'{1'b1, 1'b0, S_SD, ST_F, K_FETCHR, '0}, "rm.f", 0);
    apply(vec_t'{1'b0, 1'b0, S_SD, ST_D, K_NONE, '0}, "rm.d", 1);
    apply(vec_t'{1'b0, 1'b0, S_SD, ST_E, K_EX_LS, '0}, "rm.e", 2);
    mem_ready = 1'b0;
    #1;
    check("rm.mem.state", 64'(state),     64'(ST_M));
    check("rm.mem.ctl",   64'(act_ctl()), 64'(K_MEM_ST));
    #2;
    do_reset("rm.rst");
    apply(vec_t'{1'b0, 1'b0, S_SD, ST_F, K_FETCH, '0}, "rm.after0", 0);
    apply(vec_t'{1'b1, 1'b0, S_SD, ST_F, K_FETCHR, '0}, "rm.after1", 1);
    apply(vec_t'{1'b0, 1'b0, S_SD, ST_D, K_NONE, '0}, "rm.after2", 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
